frame_stream_ctrl: RTL
======================

// Module: frame_stream_ctrl
// PURPOSE
// Sequences one capture frame: on start, asserts collect to the capture datapath and counts LENGTH accepted samples.
// It then reads the LENGTH-entry frame buffer (1-cycle read latency) and streams it to the S2MM AXI-Stream DMA port.
// Honours tready back-pressure through a 2-entry skid buffer and generates tlast. Reports busy, a done pulse and a frame count.
// PARAMETERS
// DATA_SIZE    12     sample width, bits (<=32)
// LENGTH       32768  samples per frame (power of 2, >=4)
// LENGTH_SIZE  15     log2(LENGTH); width of address/counters
// PORTS
// clk            in   1            single clock; all logic on its rising edge
// rst            in   1            synchronous, active-high reset
// start          in   1            1-cycle pulse: begin frame (IDLE only)
// abort          in   1            cancel collection (COLLECT only)
// sample_valid   in   1            capture datapath accepted one sample
// collect        out  1            enable to capture datapath
// rd_en          out  1            frame-buffer read strobe
// rd_addr        out  LENGTH_SIZE  frame-buffer read address
// rd_data        in   DATA_SIZE    read data, valid 1 cycle after rd_en
// m_axis_tdata   out  32           zero-extended sample
// m_axis_tkeep   out  4            constant 4'hF
// m_axis_tlast   out  1            high on final beat of frame
// m_axis_tvalid  out  1            beat valid
// m_axis_tready  in   1            DMA ready
// busy           out  1            state != IDLE
// done           out  1            1-cycle pulse after final beat accepted
// frame_cnt      out  16           completed frames, wraps 16'hFFFF->0
// BEHAVIOUR
// - Reset: state IDLE; collect, rd_en, tvalid, tlast, busy, done = 0; rd_addr, frame_cnt = 0; skid buffer empty; tkeep = 4'hF.
// - States: IDLE -> COLLECT -> DRAIN -> DONE -> IDLE.
// - IDLE: start=1 -> COLLECT next cycle; sample counter cleared; start ignored in every other state.
// - COLLECT: collect=1; counter increments on sample_valid.
//   - sample_valid with count==LENGTH-1 -> DRAIN; collect=0 from the next cycle.
//   - abort=1 -> IDLE next cycle; no stream output, frame_cnt unchanged.
//   - abort and final sample in the same cycle: abort wins.
// - DRAIN: issues rd_en for rd_addr 0..LENGTH-1 in order.
//   - Read issued only when (skid occupancy + reads in flight) < 2, so no data is ever dropped.
//   - With tready held high, one beat per cycle; first tvalid 2 cycles after DRAIN entry.
//   - Returned data enters skid buffer; head drives tdata = {(32-DATA_SIZE)'b0, data}.
//   - tvalid/tdata/tlast are stable while tvalid=1 and tready=0.
//   - tlast=1 exactly on the beat carrying address LENGTH-1.
//   - abort ignored in DRAIN to preserve AXIS compliance.
// - DONE: entered when the tlast beat handshakes; done=1 for that one cycle; frame_cnt += 1; -> IDLE next cycle.
// - busy=1 in COLLECT, DRAIN, DONE; a start in the DONE cycle is ignored.
// - rst mid-frame: immediate return to reset values at the next edge; skid contents discarded.
// CONFIGURATION
// - STREAM_HDR_EN defined: one header beat precedes the data in each frame.
//   - Header tdata = {16'hF0A5, frame_cnt}, tlast=0; frame is LENGTH+1 beats.
//   - Header has the same back-pressure rules as data beats; reads begin when the header is accepted.
// - STREAM_HDR_EN undefined: no header; exactly LENGTH beats, first beat is rd_addr 0.
// TESTING (bench: DATA_SIZE=4, LENGTH=16, LENGTH_SIZE=4, buffer preloaded mem[i]=i)
// - Reset: assert rst mid-DRAIN -> next cycle tvalid=0, busy=0, rd_addr=0, collect=0.
// - Normal frame: start, 16 sample_valid, tready=1 -> 16 beats tdata 0..15, tlast only on 15, done pulse, frame_cnt=1.
// - Back-pressure: tready toggles 1,0,0,1... -> same 16 values in order, none lost or duplicated, tdata stable while stalled.
// - Abort: abort after 5 samples -> IDLE, no tvalid, frame_cnt=0; a new start then completes a full frame.
// - Ignored start: pulse start during DRAIN and DONE -> no effect; exactly one frame output.
// - With STREAM_HDR_EN on 2nd frame: first beat 32'hF0A50001, then 0..15, 17 beats total.

Source files
------------

// File: rtl/frame_stream_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : frame_stream_ctrl_if
// Brief    : 32-bit AXI4-Stream master/slave bundle for the S2MM DMA port.
// Revision : 1.0 - initial release
// ============================================================================
interface frame_stream_ctrl_if;
    logic [31:0] tdata;
    logic [3:0]  tkeep;
    logic        tlast;
    logic        tvalid;
    logic        tready;

    modport master (
        output tdata,
        output tkeep,
        output tlast,
        output tvalid,
        input  tready
    );

    modport slave (
        input  tdata,
        input  tkeep,
        input  tlast,
        input  tvalid,
        output tready
    );
endinterface
`default_nettype wire

// File: rtl/frame_stream_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : frame_stream_ctrl
// Brief    : Collects one LENGTH-sample frame, then streams the frame buffer
//            out over AXI-Stream via a 2-entry skid buffer with tlast/done.
//            Optional STREAM_HDR_EN: prepends a {16'hF0A5, frame_cnt} beat.
// Revision : 1.0 - initial release
// ============================================================================
module frame_stream_ctrl #(
    parameter int DATA_SIZE   = 12,
    parameter int LENGTH      = 32768,
    parameter int LENGTH_SIZE = 15
) (
    input  wire logic                   clk,
    input  wire logic                   rst,
    input  wire logic                   start,
    input  wire logic                   abort,
    input  wire logic                   sample_valid,
    output logic                        collect,
    output logic                        rd_en,
    output logic [LENGTH_SIZE-1:0]      rd_addr,
    input  wire logic [DATA_SIZE-1:0]   rd_data,
    frame_stream_ctrl_if.master         m_axis,
    output logic                        busy,
    output logic                        done,
    output logic [15:0]                 frame_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_DRAIN   = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    localparam logic [LENGTH_SIZE-1:0] c_last_addr = LENGTH_SIZE'(LENGTH - 1);

    state_t                 r_state;
    logic [LENGTH_SIZE-1:0] r_cnt;
    logic [LENGTH_SIZE-1:0] r_rd_addr;
    logic                   r_rd_done;
    logic                   r_collect;
    logic                   r_busy;
    logic                   r_done;
    logic [15:0]            r_frame_cnt;

    logic                   r_inflight;
    logic                   r_inflight_last;
    logic [1:0]             r_occ;
    logic [31:0]            r_skid_data [2];
    logic                   r_skid_last [2];

    logic [31:0]            w_sample_ext;
    logic                   w_pop;
    logic                   w_space;
    logic                   w_rd_en;
    logic                   w_enter_drain;
    logic                   w_hdr_ok;
    logic [1:0]             w_occ_after_pop;

    generate
        if (DATA_SIZE < 32) begin : g_pad
            assign w_sample_ext = {{(32-DATA_SIZE){1'b0}}, rd_data};
        end else begin : g_full
            assign w_sample_ext = rd_data;
        end
    endgenerate

    assign w_pop           = (r_occ != 2'd0) && m_axis.tready;
    assign w_occ_after_pop = r_occ - {1'b0, w_pop};
    // Count the beat leaving this cycle so a steady tready=1 stream runs at full rate.
    assign w_space         = ({1'b0, r_occ} + {2'b00, r_inflight}) < (3'd2 + {2'b00, w_pop});
    assign w_enter_drain   = (r_state == ST_COLLECT) && !abort && sample_valid
                             && (r_cnt == c_last_addr);
    assign w_rd_en         = (r_state == ST_DRAIN) && !r_rd_done && w_hdr_ok && w_space;

`ifdef STREAM_HDR_EN
    localparam logic [15:0] c_hdr_tag = 16'hF0A5;
    logic r_hdr_done;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_hdr_done <= 1'b0;
        end else if (w_enter_drain) begin
            r_hdr_done <= 1'b0;
        end else if ((r_state == ST_DRAIN) && w_pop) begin
            r_hdr_done <= 1'b1;
        end
    end
    assign w_hdr_ok = r_hdr_done;
`else
    assign w_hdr_ok = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_rd_addr   <= '0;
            r_rd_done   <= 1'b0;
            r_collect   <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_frame_cnt <= 16'd0;
        end else begin
            r_done <= 1'b0;
            if (w_rd_en) begin
                r_rd_addr <= r_rd_addr + LENGTH_SIZE'(1);
                if (r_rd_addr == c_last_addr) begin
                    r_rd_done <= 1'b1;
                end
            end
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_state   <= ST_COLLECT;
                        r_cnt     <= '0;
                        r_collect <= 1'b1;
                        r_busy    <= 1'b1;
                    end
                end
                ST_COLLECT: begin
                    if (abort) begin
                        r_state   <= ST_IDLE;
                        r_collect <= 1'b0;
                        r_busy    <= 1'b0;
                    end else if (sample_valid) begin
                        if (r_cnt == c_last_addr) begin
                            r_state   <= ST_DRAIN;
                            r_collect <= 1'b0;
                            r_rd_addr <= '0;
                            r_rd_done <= 1'b0;
                        end else begin
                            r_cnt <= r_cnt + LENGTH_SIZE'(1);
                        end
                    end
                end
                ST_DRAIN: begin
                    if (w_pop && r_skid_last[0]) begin
                        r_state     <= ST_DONE;
                        r_done      <= 1'b1;
                        r_frame_cnt <= r_frame_cnt + 16'd1;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Skid buffer: entry 0 is the head; a pop shifts, a push lands behind what remains.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_occ           <= 2'd0;
            r_inflight      <= 1'b0;
            r_inflight_last <= 1'b0;
        end else begin
            r_inflight      <= w_rd_en;
            r_inflight_last <= w_rd_en && (r_rd_addr == c_last_addr);
            if (w_pop) begin
                r_skid_data[0] <= r_skid_data[1];
                r_skid_last[0] <= r_skid_last[1];
            end
            if (r_inflight) begin
                r_skid_data[w_occ_after_pop[0]] <= w_sample_ext;
                r_skid_last[w_occ_after_pop[0]] <= r_inflight_last;
            end
            r_occ <= r_occ + {1'b0, r_inflight} - {1'b0, w_pop};
`ifdef STREAM_HDR_EN
            if (w_enter_drain) begin
                r_skid_data[0] <= {c_hdr_tag, r_frame_cnt};
                r_skid_last[0] <= 1'b0;
                r_occ          <= 2'd1;
            end
`endif
        end
    end

    assign collect       = r_collect;
    assign rd_en         = w_rd_en;
    assign rd_addr       = r_rd_addr;
    assign busy          = r_busy;
    assign done          = r_done;
    assign frame_cnt     = r_frame_cnt;
    assign m_axis.tdata  = r_skid_data[0];
    assign m_axis.tkeep  = 4'hF;
    assign m_axis.tvalid = (r_occ != 2'd0);
    assign m_axis.tlast  = (r_occ != 2'd0) && r_skid_last[0];

endmodule
`default_nettype wire
